mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage data-bus access unit for the pipelined core, the parametrised successor to the single-cycle full-strobe store path. It sits between the execute/memory pipeline register and the data bus. It converts byte/half/word/double loads and stores into sized, strobed bus transactions and runs the multi-cycle `addr_ok`/`data_ok` handshake. It returns sign- or zero-extended load data and asserts `stall` to freeze the pipeline until the access completes.

## Interface
Parameters:
- `XLEN`, 64: data width. Legal values are 32 or 64. `NB = XLEN/8`; `OFF = log2(NB)`.
- `AW`, 64: address width.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a memory-stage instruction is present.
- `req_read` in 1: the instruction is a load.
- `req_write` in 1: the instruction is a store. `req_read` and `req_write` are never both high.
- `req_size` in 2: access size. 0=B, 1=H, 2=W, 3=D. D is illegal when XLEN=32.
- `req_unsigned` in 1: zero-extend load data.
- `req_addr` in AW: byte address.
- `req_wdata` in XLEN: store data, right-aligned.
- `flush` in 1: discard the current memory-stage instruction.
- `dreq_valid` out 1, `dreq_addr` out AW, `dreq_size` out 2, `dreq_strobe` out NB, `dreq_data` out XLEN: bus request.
- `dresp_addr_ok` in 1: the bus accepted the request.
- `dresp_data_ok` in 1: the bus completed the transfer.
- `dresp_data` in XLEN: bus read data.
- `resp_valid` out 1: access done this cycle.
- `resp_data` out XLEN: extended load data. Zero for stores.
- `misalign` out 1: misaligned access, valid together with `resp_valid`.
- `stall` out 1: hold all upstream pipeline registers.

## Operation
- The FSM has four states: IDLE, REQ, WAIT and DONE.
- IDLE: a memory op is `req_valid & (req_read|req_write) & ~flush`.
  - An aligned op latches address, size, unsigned, read/write, strobe and shifted data, then goes to REQ.
  - A misaligned op with trap enabled goes to DONE with `misalign_q=1` and issues no bus request.
  - A non-memory op or a flushed op stays in IDLE.
- REQ: `dreq_valid=1` and all dreq fields come from the latched registers.
  - On `addr_ok & data_ok`: capture `dresp_data` and go to DONE.
  - On `addr_ok` alone: go to WAIT.
  - Otherwise stay in REQ with every field held stable.
- WAIT: `dreq_valid=0`. On `data_ok`, capture data and go to DONE.
- DONE: `resp_valid=1` unless the drop flag is set. Next state is IDLE unconditionally.
- `stall = (state==IDLE & accepted op) | state==REQ | state==WAIT`. `stall` is 0 in DONE so the pipeline advances on the same edge that `resp_valid` is consumed.
- Alignment rule: an access is aligned when `addr % (1<<size) == 0`.
- Strobe:
  - B gives `1 << addr[OFF-1:0]`.
  - H gives `3 << off`.
  - W gives `4'hF << off`.
  - D gives all ones.
- Store data: `dreq_data = req_wdata << (8*off)`. Unstrobed bytes are don't-care and driven from the shifted value.
- Load data: `raw = dresp_data >> (8*off)`, truncated to the access size, then sign-extended (`req_unsigned=0`) or zero-extended to XLEN.
- `flush` in REQ or WAIT sets a drop flag. The bus transaction still completes (no abandoned handshake), but DONE then asserts neither `resp_valid` nor `misalign`. The drop flag clears on the return to IDLE.

## Timing
- Reset values: state=IDLE, drop=0. Every output is 0: `dreq_*`, `resp_valid`, `resp_data`, `misalign`, `stall`.
- Assertion of `reset` mid-transaction returns the unit to IDLE immediately. The external bus is reset in the same domain.
- Minimum latency, accept to `resp_valid`, is 2 cycles: the IDLE cycle, then REQ with addr_ok and data_ok together, then DONE. Each bus wait cycle adds one cycle.
- Misaligned trap latency is 1 cycle: IDLE, then DONE.
- `resp_data` and `misalign` are registered and stable throughout DONE.
- `dreq_*` outputs are registered and unchanged from entry into REQ until `addr_ok`.

## Configuration
- `MAU_MISALIGN_TRAP_EN` defined: misaligned accesses behave as described in Operation. There is no bus access and `misalign=1` with `resp_valid`.
- `MAU_MISALIGN_TRAP_EN` undefined:
  - The low `size` address bits are forced to zero, the access proceeds as an aligned access, and `misalign` is tied to 0.
  - The DONE-without-bus path is removed.

## Test plan
- XLEN=64. Store W to `0x8000_0006`, wdata `0x1122_3344`, with the trap macro defined. Required: no dreq, `misalign=1` and `resp_valid=1` at cycle 1.
- Load B from `0x8000_0003`, `req_unsigned=0`, `dresp_data=0x0000_0000_80xx_xxxx` with byte 3 = `0x80`, `addr_ok` and `data_ok` in the same cycle. Required: `dreq_strobe=0x08` and `resp_data=0xFFFF_FFFF_FFFF_FF80` at cycle 2.
- Store H to `0x8000_0004`, wdata `0xBEEF`, `addr_ok` delayed 3 cycles. Required: `dreq_strobe=0x30`, `dreq_data[47:32]=0xBEEF`, all dreq fields stable for 3 cycles, and `stall` high through WAIT.
- Load D from `0x8000_0010` with `addr_ok` at cycle 1 and `data_ok` at cycle 4. Required: REQ→WAIT→DONE, `resp_data` equals `dresp_data`, and `resp_valid` at cycle 5.
- `flush` asserted in WAIT. Required: the bus still completes, then `resp_valid=0` in DONE, and the next op is accepted in IDLE.
- `reset` pulled low in REQ. Required: all outputs 0 immediately, and state is IDLE after `reset` deasserts.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage data-bus access unit: sized/strobed loads and stores over an addr_ok/data_ok bus.
// Define MAU_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise low address bits are forced to zero.
module mem_access_unit #(
    parameter int XLEN = 64,
    parameter int AW   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              flush,
    output logic              dreq_valid,
    output logic [AW-1:0]     dreq_addr,
    output logic [1:0]        dreq_size,
    output logic [XLEN/8-1:0] dreq_strobe,
    output logic [XLEN-1:0]   dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [XLEN-1:0]   dresp_data,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_data,
    output logic              misalign,
    output logic              stall
);

    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);

`ifdef MAU_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic            read_q, read_d;
    logic [NB-1:0]   strobe_q, strobe_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            misalign_q, misalign_d;
    logic            drop_q, drop_d;

    // Request decode, only meaningful while IDLE.
    logic            mem_op;
    logic            misaligned;
    logic [OFF-1:0]  size_mask;
    logic [OFF-1:0]  req_off;
    logic [NB-1:0]   req_strobe;

    assign mem_op     = req_valid & (req_read | req_write) & ~flush;
    assign size_mask  = OFF'((1 << req_size) - 1);
    assign misaligned = |(req_addr[OFF-1:0] & size_mask);
    // Clearing the low size bits is a no-op for aligned accesses, so one path serves both builds.
    assign req_off    = req_addr[OFF-1:0] & ~size_mask;

    always_comb begin
        case (req_size)
            2'd0:    req_strobe = NB'(1)  << req_off;
            2'd1:    req_strobe = NB'(3)  << req_off;
            2'd2:    req_strobe = NB'(15) << req_off;
            default: req_strobe = '1;
        endcase
    end

    // Load alignment and extension from the latched offset, size and signedness.
    logic [OFF-1:0]  off_q;
    logic [XLEN-1:0] load_raw;
    logic [XLEN-1:0] load_mask;
    logic            load_sign;
    logic [XLEN-1:0] load_ext;

    assign off_q    = addr_q[OFF-1:0];
    assign load_raw = dresp_data >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    begin load_mask = XLEN'(8'hFF);         load_sign = load_raw[7];      end
            2'd1:    begin load_mask = XLEN'(16'hFFFF);      load_sign = load_raw[15];     end
            2'd2:    begin load_mask = XLEN'(32'hFFFF_FFFF); load_sign = load_raw[31];     end
            default: begin load_mask = '1;                   load_sign = load_raw[XLEN-1]; end
        endcase
        load_ext = (load_raw & load_mask) | ((load_sign & ~uns_q) ? ~load_mask : '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: datapath registers are reset too, because every output must read 0 during reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            read_q     <= 1'b0;
            strobe_q   <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            read_q     <= read_d;
            strobe_q   <= strobe_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            drop_q     <= drop_d;
        end
    end

    // NOTE: every next-state signal is defaulted to its current value first, so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        read_d     = read_q;
        strobe_d   = strobe_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        drop_d     = drop_q;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (TrapEn && misaligned) begin
                        misalign_d = 1'b1;
                        rdata_d    = '0;
                        state_d    = DONE;
                    end else begin
                        addr_d   = {req_addr[AW-1:OFF], req_off};
                        size_d   = req_size;
                        uns_d    = req_unsigned;
                        read_d   = req_read;
                        strobe_d = req_strobe;
                        wdata_d  = req_wdata << {req_off, 3'b000};
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                drop_d = drop_q | flush;
                if (dresp_addr_ok && dresp_data_ok) begin
                    rdata_d = read_q ? load_ext : '0;
                    state_d = DONE;
                end else if (dresp_addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                drop_d = drop_q | flush;
                if (dresp_data_ok) begin
                    rdata_d = read_q ? load_ext : '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                rdata_d    = '0;
                misalign_d = 1'b0;
                drop_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dreq_valid  = (state_q == REQ);
    assign dreq_addr   = addr_q;
    assign dreq_size   = size_q;
    assign dreq_strobe = strobe_q;
    assign dreq_data   = wdata_q;

    assign resp_valid  = (state_q == DONE) & ~drop_q;
    assign resp_data   = resp_valid ? rdata_q : '0;
    assign misalign    = TrapEn & resp_valid & misalign_q;

    // Gated by reset so a request sitting on the inputs cannot raise stall while in reset.
    assign stall = reset & (((state_q == IDLE) & mem_op) | (state_q == REQ) | (state_q == WAIT));

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (XLEN=64): handshake timing, strobes, load extension, flush and reset.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        flush;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        misalign;
    logic        stall;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(.XLEN(64), .AW(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .flush         (flush),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .misalign      (misalign),
        .stall         (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clear_req();
        req_valid    = 1'b0;
        req_read     = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        flush        = 1'b0;
    endtask

    task automatic present(input logic rd, input logic [1:0] sz, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wdata);
        req_valid    = 1'b1;
        req_read     = rd;
        req_write    = ~rd;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    // Two-cycle access: accept in IDLE, REQ with addr_ok+data_ok together, then DONE.
    task automatic simple_access(input string tag, input logic rd, input logic [1:0] sz, input logic uns,
                                 input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rsp,
                                 input logic [63:0] exp_addr, input logic [7:0] exp_strobe,
                                 input logic [63:0] exp_bus_data, input logic [63:0] exp_resp);
        @(negedge clk);
        present(rd, sz, uns, addr, wdata);
        #1 check({tag, ".accept_stall"}, stall, 1'b1);
        @(negedge clk);
        clear_req();
        #1;
        check({tag, ".dreq_valid"}, dreq_valid, 1'b1);
        check({tag, ".dreq_addr"}, dreq_addr, exp_addr);
        check({tag, ".dreq_size"}, dreq_size, sz);
        check({tag, ".dreq_strobe"}, dreq_strobe, exp_strobe);
        if (!rd) check({tag, ".dreq_data"}, dreq_data, exp_bus_data);
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = rsp;
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        #1;
        check({tag, ".resp_valid"}, resp_valid, 1'b1);
        check({tag, ".resp_data"}, resp_data, exp_resp);
        check({tag, ".misalign"}, misalign, 1'b0);
        check({tag, ".done_stall"}, stall, 1'b0);
        check({tag, ".done_dreq_valid"}, dreq_valid, 1'b0);
    endtask

    initial begin
        clear_req();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        reset         = 1'b0;

        // Reset state, with a request parked on the inputs.
        present(1'b1, 2'd3, 1'b0, 64'h8000_0010, 64'h0);
        #1;
        check("rst.dreq_valid", dreq_valid, 1'b0);
        check("rst.dreq_addr", dreq_addr, 64'h0);
        check("rst.dreq_size", dreq_size, 2'd0);
        check("rst.dreq_strobe", dreq_strobe, 8'h00);
        check("rst.dreq_data", dreq_data, 64'h0);
        check("rst.resp_valid", resp_valid, 1'b0);
        check("rst.resp_data", resp_data, 64'h0);
        check("rst.misalign", misalign, 1'b0);
        check("rst.stall", stall, 1'b0);
        clear_req();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Misaligned store W to 0x8000_0006.
        @(negedge clk);
        present(1'b0, 2'd2, 1'b0, 64'h8000_0006, 64'h1122_3344);
        #1 check("mis.accept_stall", stall, 1'b1);
        @(negedge clk);
        clear_req();
        #1;
`ifdef MAU_MISALIGN_TRAP_EN
        check("mis.dreq_valid", dreq_valid, 1'b0);
        check("mis.resp_valid", resp_valid, 1'b1);
        check("mis.misalign", misalign, 1'b1);
        check("mis.stall", stall, 1'b0);
        @(negedge clk);
        #1;
        check("mis.idle_resp_valid", resp_valid, 1'b0);
        check("mis.idle_misalign", misalign, 1'b0);
`else
        check("mis.dreq_valid", dreq_valid, 1'b1);
        check("mis.dreq_addr", dreq_addr, 64'h8000_0004);
        check("mis.dreq_strobe", dreq_strobe, 8'hF0);
        check("mis.dreq_data", dreq_data, 64'h1122_3344_0000_0000);
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        #1;
        check("mis.resp_valid", resp_valid, 1'b1);
        check("mis.misalign", misalign, 1'b0);
        check("mis.resp_data", resp_data, 64'h0);
`endif

        // Loads with sign/zero extension at various offsets.
        simple_access("ldb_s", 1'b1, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 64'h0000_0000_8011_2233,
                      64'h8000_0003, 8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
        simple_access("ldb_u", 1'b1, 2'd0, 1'b1, 64'h8000_0003, 64'h0, 64'h0000_0000_8011_2233,
                      64'h8000_0003, 8'h08, 64'h0, 64'h0000_0000_0000_0080);
        simple_access("ldh_u", 1'b1, 2'd1, 1'b1, 64'h8000_0002, 64'h0, 64'h0000_0000_ABCD_0000,
                      64'h8000_0002, 8'h0C, 64'h0, 64'h0000_0000_0000_ABCD);
        simple_access("ldw_s", 1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000,
                      64'h8000_0004, 8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321);
        simple_access("stb", 1'b0, 2'd0, 1'b0, 64'h8000_0005, 64'h0000_0000_0000_00A5, 64'hFFFF_FFFF_FFFF_FFFF,
                      64'h8000_0005, 8'h20, 64'h0000_A500_0000_0000, 64'h0);

        // Store H with addr_ok held off for 3 cycles, then data_ok one cycle after addr_ok.
        @(negedge clk);
        present(1'b0, 2'd1, 1'b0, 64'h8000_0004, 64'h0000_0000_0000_BEEF);
        @(negedge clk);
        clear_req();
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("sth.c%0d.dreq_valid", i), dreq_valid, 1'b1);
            check($sformatf("sth.c%0d.dreq_addr", i), dreq_addr, 64'h8000_0004);
            check($sformatf("sth.c%0d.dreq_strobe", i), dreq_strobe, 8'h30);
            check($sformatf("sth.c%0d.dreq_data", i), dreq_data, 64'h0000_BEEF_0000_0000);
            check($sformatf("sth.c%0d.stall", i), stall, 1'b1);
            if (i == 4) dresp_addr_ok = 1'b1;
            @(negedge clk);
        end
        dresp_addr_ok = 1'b0;
        #1;
        check("sth.wait_dreq_valid", dreq_valid, 1'b0);
        check("sth.wait_stall", stall, 1'b1);
        dresp_data_ok = 1'b1;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        #1;
        check("sth.resp_valid", resp_valid, 1'b1);
        check("sth.resp_data", resp_data, 64'h0);
        check("sth.stall", stall, 1'b0);

        // Load D: addr_ok at cycle 1, data_ok at cycle 4, resp_valid at cycle 5.
        @(negedge clk);
        present(1'b1, 2'd3, 1'b0, 64'h8000_0010, 64'h0);
        @(negedge clk);
        clear_req();
        #1;
        check("ldd.dreq_strobe", dreq_strobe, 8'hFF);
        check("ldd.dreq_valid", dreq_valid, 1'b1);
        dresp_addr_ok = 1'b1;
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        #1;
        check("ldd.c2_dreq_valid", dreq_valid, 1'b0);
        check("ldd.c2_resp_valid", resp_valid, 1'b0);
        @(negedge clk);
        #1 check("ldd.c3_stall", stall, 1'b1);
        @(negedge clk);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hDEAD_BEEF_CAFE_F00D;
        #1 check("ldd.c4_resp_valid", resp_valid, 1'b0);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        #1;
        check("ldd.c5_resp_valid", resp_valid, 1'b1);
        check("ldd.c5_resp_data", resp_data, 64'hDEAD_BEEF_CAFE_F00D);

        // Flush in WAIT: the bus completes but the response is dropped.
        @(negedge clk);
        present(1'b1, 2'd2, 1'b0, 64'h8000_0008, 64'h0);
        @(negedge clk);
        clear_req();
        dresp_addr_ok = 1'b1;
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        flush         = 1'b1;
        #1 check("flw.wait_stall", stall, 1'b1);
        @(negedge clk);
        flush         = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_0000_1234_5678;
        #1 check("flw.wait2_stall", stall, 1'b1);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        #1;
        check("flw.done_resp_valid", resp_valid, 1'b0);
        check("flw.done_resp_data", resp_data, 64'h0);
        check("flw.done_stall", stall, 1'b0);
        simple_access("flw.next", 1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000,
                      64'h8000_0006, 8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_8001);

        // Flushed op in IDLE is not accepted.
        @(negedge clk);
        present(1'b1, 2'd0, 1'b0, 64'h8000_0001, 64'h0);
        flush = 1'b1;
        #1 check("fli.stall", stall, 1'b0);
        @(negedge clk);
        clear_req();
        #1 check("fli.dreq_valid", dreq_valid, 1'b0);

        // Reset pulled low while in REQ.
        @(negedge clk);
        present(1'b0, 2'd3, 1'b0, 64'h8000_0018, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        #1 check("rreq.dreq_valid", dreq_valid, 1'b1);
        reset = 1'b0;
        #1;
        check("rreq.dreq_valid0", dreq_valid, 1'b0);
        check("rreq.dreq_addr0", dreq_addr, 64'h0);
        check("rreq.dreq_strobe0", dreq_strobe, 8'h00);
        check("rreq.dreq_data0", dreq_data, 64'h0);
        check("rreq.resp_valid0", resp_valid, 1'b0);
        check("rreq.stall0", stall, 1'b0);
        clear_req();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rreq.idle_dreq_valid", dreq_valid, 1'b0);
        check("rreq.idle_stall", stall, 1'b0);
        simple_access("rreq.next", 1'b0, 2'd3, 1'b0, 64'h8000_0018, 64'h0123_4567_89AB_CDEF, 64'h0,
                      64'h8000_0018, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
